// File: rtl/fsk_defs.sv
// -----------------------------------------------------------------------------
// fsk_defs
// Shared FSK definitions: the 2-bit sequencer state encoding and the default
// mark/space phase increments. The NCO testbench uses the same constants.
// -----------------------------------------------------------------------------
package fsk_defs;

    // Sequencer states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } fsk_state_t;

    // Default NCO phase increments for the two tones.
    localparam logic [7:0] DEFAULT_MARK_INC  = 8'd20;
    localparam logic [7:0] DEFAULT_SPACE_INC = 8'd37;

    // Tone for one data bit: 1 -> mark, 0 -> space.
    function automatic logic [7:0] symbol_inc(input logic       b,
                                              input logic [7:0] mark_inc,
                                              input logic [7:0] space_inc);
        return b ? mark_inc : space_inc;
    endfunction

endpackage

// File: rtl/baud_timer.sv
// -----------------------------------------------------------------------------
// baud_timer
// Symbol-period counter. Counts 0..BAUD_DIV-1 and wraps; tick is high during
// the terminal count, i.e. the last cycle of every symbol.
//
// Ports
//   clock : rising-edge clock
//   reset : asynchronous, active-high reset (count -> 0)
//   clear : synchronous clear, holds the count at 0
//   tick  : terminal-count strobe (combinational from the count)
// -----------------------------------------------------------------------------
module baud_timer #(
    parameter int unsigned BAUD_DIV = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = $clog2(BAUD_DIV);

    logic [CW-1:0] count;

    assign tick = (count == CW'(BAUD_DIV - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/fsk_symbol_sequencer.sv
// -----------------------------------------------------------------------------
// fsk_symbol_sequencer
// Serialises bytes into FSK symbols for an NCO. Each frame is one space start
// symbol, eight data symbols LSB first and one mark stop symbol, each lasting
// BAUD_DIV clocks. The idle line carries the mark tone. A new byte may be
// accepted in the last stop cycle, so streamed frames run without a gap.
//
// Ports
//   clock           : rising-edge clock
//   reset           : asynchronous, active-high reset
//   data            : byte to send, sampled on the accept edge only
//   data_valid      : upstream has a byte on data
//   data_ready      : block can take a byte this cycle (combinational)
//   phase_increment : registered NCO phase increment for the current symbol
//   busy            : registered, high from first START cycle to last STOP cycle
// -----------------------------------------------------------------------------
module fsk_symbol_sequencer
    import fsk_defs::*;
#(
    parameter int unsigned BAUD_DIV  = 16,
    parameter logic [7:0]  MARK_INC  = DEFAULT_MARK_INC,
    parameter logic [7:0]  SPACE_INC = DEFAULT_SPACE_INC
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       data_ready,
    output logic [7:0] phase_increment,
    output logic       busy
);

    fsk_state_t state;
    logic [7:0] shift_reg;
    logic [2:0] bit_index;
    logic       tick;
    logic       accept;

    // The timer is held at 0 while idle so the first symbol after an accept
    // gets its full BAUD_DIV cycles; between back-to-back frames it simply wraps.
    baud_timer #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_timer (
        .clock (clock),
        .reset (reset),
        .clear (state == IDLE),
        .tick  (tick)
    );

    // NOTE: data_ready is a continuous assignment from state and tick, so it
    // is purely combinational with no path that could infer a latch.
    assign data_ready = (state == IDLE) || (state == STOP && tick);
    assign accept     = data_valid && data_ready;

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every branch reads the pre-edge values (shift_reg[1] below relies on it).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            phase_increment <= MARK_INC;
            busy            <= 1'b0;
            shift_reg       <= '0;
            bit_index       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state           <= START;
                        phase_increment <= SPACE_INC;
                        busy            <= 1'b1;
                        shift_reg       <= data;
                    end
                end

                START: begin
                    if (tick) begin
                        state           <= DATA;
                        phase_increment <= symbol_inc(shift_reg[0], MARK_INC, SPACE_INC);
                        bit_index       <= '0;
                    end
                end

                DATA: begin
                    if (tick) begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_index == 3'd7) begin
                            state           <= STOP;
                            phase_increment <= MARK_INC;
                            bit_index       <= '0;
                        end else begin
                            // Next bit is shift_reg[1] before this edge's shift.
                            bit_index       <= bit_index + 3'd1;
                            phase_increment <= symbol_inc(shift_reg[1], MARK_INC, SPACE_INC);
                        end
                    end
                end

                STOP: begin
                    if (tick) begin
                        if (accept) begin
                            state           <= START;
                            phase_increment <= SPACE_INC;
                            shift_reg       <= data;
                        end else begin
                            state           <= IDLE;
                            phase_increment <= MARK_INC;
                            busy            <= 1'b0;
                        end
                    end
                end

                default: begin
                    state           <= IDLE;
                    phase_increment <= MARK_INC;
                    busy            <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsk_symbol_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fsk_symbol_sequencer
// Self-checking bench. dut runs with BAUD_DIV=4, dut2 with BAUD_DIV=2; both use
// mark=20, space=37. Expected per-cycle phase increments are pushed to a queue
// when a byte is offered and popped as the DUT produces each symbol cycle.
// -----------------------------------------------------------------------------
module tb_fsk_symbol_sequencer;

    localparam logic [7:0] MARK  = 8'd20;
    localparam logic [7:0] SPACE = 8'd37;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] data, data2;
    logic       data_valid, data_valid2;
    logic       data_ready, data_ready2;
    logic [7:0] phase_increment, phase_increment2;
    logic       busy, busy2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp2_q[$];

    // Behavioural NCO phase accumulator driven by dut.
    logic [7:0] nco_acc = 8'd0;

    fsk_symbol_sequencer #(.BAUD_DIV(4), .MARK_INC(MARK), .SPACE_INC(SPACE)) dut (
        .clock           (clock),
        .reset           (reset),
        .data            (data),
        .data_valid      (data_valid),
        .data_ready      (data_ready),
        .phase_increment (phase_increment),
        .busy            (busy)
    );

    fsk_symbol_sequencer #(.BAUD_DIV(2), .MARK_INC(MARK), .SPACE_INC(SPACE)) dut2 (
        .clock           (clock),
        .reset           (reset),
        .data            (data2),
        .data_valid      (data_valid2),
        .data_ready      (data_ready2),
        .phase_increment (phase_increment2),
        .busy            (busy2)
    );

    always #5 clock = ~clock;

    always @(posedge clock) nco_acc <= nco_acc + phase_increment;

    // Expected per-cycle tone of one frame: start, 8 data bits LSB first, stop.
    task automatic push_frame(input logic [7:0] b, input int bd, input bit second);
        logic [7:0] sym;
        for (int s = 0; s < 10; s++) begin
            if (s == 0)      sym = SPACE;
            else if (s == 9) sym = MARK;
            else             sym = b[s-1] ? MARK : SPACE;
            for (int c = 0; c < bd; c++) begin
                if (second) exp2_q.push_back(sym);
                else        exp_q.push_back(sym);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        data = 8'h00; data_valid = 1'b0;
        data2 = 8'h00; data_valid2 = 1'b0;
        #2;
        n_checks++;
        if (phase_increment !== MARK) begin
            n_fail++; $display("FAIL reset_phase got=%0d exp=%0d", phase_increment, MARK);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got=%b exp=0", busy);
        end
        n_checks++;
        if (data_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready got=%b exp=1", data_ready);
        end
        n_checks++;
        if (phase_increment2 !== MARK || busy2 !== 1'b0 || data_ready2 !== 1'b1) begin
            n_fail++; $display("FAIL reset_dut2 got=%0d/%b/%b exp=20/0/1",
                               phase_increment2, busy2, data_ready2);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Offered on the same negedge as reset release: accepts on the first edge.
    task automatic test_single_a5;
        data = 8'hA5; data_valid = 1'b1;
        push_frame(8'hA5, 4, 1'b0);
        for (int i = 0; i < 40; i++) begin
            logic [7:0] e;
            @(negedge clock);
            if (i == 0) data_valid = 1'b0;
            e = exp_q.pop_front();
            n_checks++;
            if (phase_increment !== e) begin
                n_fail++; $display("FAIL a5_phase cyc=%0d got=%0d exp=%0d", i, phase_increment, e);
            end
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++; $display("FAIL a5_busy cyc=%0d got=%b exp=1", i, busy);
            end
            n_checks++;
            if (data_ready !== (i == 39)) begin
                n_fail++; $display("FAIL a5_ready cyc=%0d got=%b exp=%b", i, data_ready, i == 39);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_checks++;
            if (phase_increment !== MARK || busy !== 1'b0 || data_ready !== 1'b1) begin
                n_fail++; $display("FAIL a5_idle cyc=%0d got=%0d/%b/%b exp=20/0/1",
                                   i, phase_increment, busy, data_ready);
            end
        end
    endtask

    task automatic test_back_to_back;
        data = 8'h00; data_valid = 1'b1;
        push_frame(8'h00, 4, 1'b0);
        push_frame(8'hFF, 4, 1'b0);
        for (int i = 0; i < 80; i++) begin
            logic [7:0] e;
            @(negedge clock);
            if (i == 0)  data = 8'hFF;
            if (i == 40) data_valid = 1'b0;
            e = exp_q.pop_front();
            n_checks++;
            if (phase_increment !== e) begin
                n_fail++; $display("FAIL b2b_phase cyc=%0d got=%0d exp=%0d", i, phase_increment, e);
            end
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++; $display("FAIL b2b_busy cyc=%0d got=%b exp=1", i, busy);
            end
            n_checks++;
            if (data_ready !== (i == 39 || i == 79)) begin
                n_fail++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b",
                                   i, data_ready, (i == 39 || i == 79));
            end
        end
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b0 || phase_increment !== MARK) begin
            n_fail++; $display("FAIL b2b_idle got=%b/%0d exp=0/20", busy, phase_increment);
        end
    endtask

    // data_valid stays high and data keeps changing while the frame is busy.
    task automatic test_hold_while_busy;
        data = 8'h3C; data_valid = 1'b1;
        push_frame(8'h3C, 4, 1'b0);
        for (int i = 0; i < 40; i++) begin
            logic [7:0] e;
            @(negedge clock);
            data = 8'($urandom_range(0, 255));
            if (i == 38) data_valid = 1'b0;
            e = exp_q.pop_front();
            n_checks++;
            if (phase_increment !== e) begin
                n_fail++; $display("FAIL hold_phase cyc=%0d got=%0d exp=%0d", i, phase_increment, e);
            end
            n_checks++;
            if (data_ready !== (i == 39)) begin
                n_fail++; $display("FAIL hold_ready cyc=%0d got=%b exp=%b", i, data_ready, i == 39);
            end
        end
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL hold_idle got=%b exp=0", busy);
        end
    endtask

    task automatic test_reset_mid_frame;
        data = 8'h5A; data_valid = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge clock);
            if (i == 0) data_valid = 1'b0;
        end
        // Assert between edges and check before the next edge arrives.
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (phase_increment !== MARK || busy !== 1'b0 || data_ready !== 1'b1) begin
            n_fail++; $display("FAIL midreset_async got=%0d/%b/%b exp=20/0/1",
                               phase_increment, busy, data_ready);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            n_checks++;
            if (phase_increment !== MARK || busy !== 1'b0) begin
                n_fail++; $display("FAIL midreset_quiet cyc=%0d got=%0d/%b exp=20/0",
                                   i, phase_increment, busy);
            end
        end
        data = 8'h96; data_valid = 1'b1;
        push_frame(8'h96, 4, 1'b0);
        for (int i = 0; i < 40; i++) begin
            logic [7:0] e;
            @(negedge clock);
            if (i == 0) data_valid = 1'b0;
            e = exp_q.pop_front();
            n_checks++;
            if (phase_increment !== e) begin
                n_fail++; $display("FAIL midreset_frame cyc=%0d got=%0d exp=%0d", i, phase_increment, e);
            end
        end
        @(negedge clock);
    endtask

    task automatic test_baud_div_2;
        data2 = 8'h01; data_valid2 = 1'b1;
        push_frame(8'h01, 2, 1'b1);
        for (int i = 0; i < 20; i++) begin
            logic [7:0] e;
            @(negedge clock);
            if (i == 0) data_valid2 = 1'b0;
            e = exp2_q.pop_front();
            n_checks++;
            if (phase_increment2 !== e) begin
                n_fail++; $display("FAIL bd2_phase cyc=%0d got=%0d exp=%0d", i, phase_increment2, e);
            end
            n_checks++;
            if (busy2 !== 1'b1 || data_ready2 !== (i == 19)) begin
                n_fail++; $display("FAIL bd2_flags cyc=%0d got=%b/%b exp=1/%b",
                                   i, busy2, data_ready2, i == 19);
            end
        end
        @(negedge clock);
        n_checks++;
        if (busy2 !== 1'b0 || phase_increment2 !== MARK) begin
            n_fail++; $display("FAIL bd2_idle got=%b/%0d exp=0/20", busy2, phase_increment2);
        end
    endtask

    // Phase advanced by the NCO over each symbol must equal BAUD_DIV x tone.
    task automatic test_nco_chain;
        logic [7:0] prev;
        logic [7:0] b;
        int         k;
        b = 8'h0F;
        k = 0;
        prev = 8'd0;
        data = b; data_valid = 1'b1;
        for (int i = 0; i <= 40; i++) begin
            @(negedge clock);
            if (i == 0) data_valid = 1'b0;
            if (i % 4 == 0) begin
                if (i > 0) begin
                    logic [7:0] tone;
                    logic [7:0] adv;
                    if (k == 0)      tone = SPACE;
                    else if (k == 9) tone = MARK;
                    else             tone = b[k-1] ? MARK : SPACE;
                    adv = 8'(4 * int'(tone));
                    n_checks++;
                    if (8'(nco_acc - prev) !== adv) begin
                        n_fail++; $display("FAIL nco_advance sym=%0d got=%0d exp=%0d",
                                           k, 8'(nco_acc - prev), adv);
                    end
                    k++;
                end
                prev = nco_acc;
            end
        end
    endtask

    initial begin
        test_reset;
        test_single_a5;
        test_back_to_back;
        test_hold_while_busy;
        test_reset_mid_frame;
        test_baud_div_2;
        test_nco_chain;
        n_checks++;
        if (exp_q.size() !== 0 || exp2_q.size() !== 0) begin
            n_fail++; $display("FAIL scoreboard_drain got=%0d/%0d exp=0/0", exp_q.size(), exp2_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
